// File: rtl/systolic_feeder.sv
// Systolic array feeder: loads one weight per PE row through the north port, then
// streams activation vectors into per-row skewed west lanes and drains them.
module systolic_feeder #(
   parameter int ROWS = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_wt_valid,
   input  logic [7:0]        i_wt_data,
   output logic              o_wt_ready,
   input  logic              i_act_valid,
   input  logic [ROWS*8-1:0] i_act_data,
   input  logic              i_act_last,
   output logic              o_act_ready,
   output logic [ROWS*9-1:0] o_west_data,
   output logic [31:0]       o_north_data,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(ROWS - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;   // weight handshakes in LOAD_W, elapsed cycles in DRAIN
   logic       wt_fire;
   logic       act_fire;

   assign o_wt_ready  = (state == LOAD_W);
   assign o_act_ready = (state == STREAM);
   assign o_busy      = (state != IDLE);
   assign o_done      = (state == DONE);

   assign wt_fire  = i_wt_valid & o_wt_ready;
   assign act_fire = i_act_valid & o_act_ready;

   // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = LOAD_W;
               cnt_nxt   = '0;
            end
         end
         LOAD_W: begin
            if (wt_fire) begin
               if (cnt == LAST_IDX) begin
                  state_nxt = STREAM;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         STREAM: begin
            if (act_fire && i_act_last) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            // Lane ROWS-1 emits the final vector in the last DRAIN cycle.
            if (cnt == LAST_IDX) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         o_north_data <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         o_north_data <= wt_fire ? {24'h0, i_wt_data} : 32'h0;
      end
   end

   // Lane r is a shift register of depth r+1, which produces the diagonal skew.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic [8:0] sr [r+1];
      logic [8:0] inj;

      assign inj = act_fire ? {1'b1, i_act_data[(ROWS-r)*8-1 -: 8]} : 9'h000;

      // NOTE: lane stages are ordinary flops, so reset clears them and a mid-job abort discards in-flight data.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int s = 0; s <= r; s++) sr[s] <= '0;
         end else begin
            sr[0] <= inj;
            for (int s = 1; s <= r; s++) sr[s] <= sr[s-1];
         end
      end

      assign o_west_data[(ROWS-r)*9-1 -: 9] = sr[r];
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a procedural job model pushes timed expectations,
// and a negedge monitor pops them whenever the DUT presents data.
module tb_systolic_feeder;

   localparam int ROWS = 3;

   typedef logic [ROWS*8-1:0] vec_t;
   typedef struct {
      int         cyc;
      logic [7:0] d;
   } ev_t;
   typedef struct {
      int         gap;
      logic [7:0] d;
   } wdir_t;
   typedef struct {
      int   gap;
      vec_t d;
   } vdir_t;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_start;
   logic              i_wt_valid;
   logic [7:0]        i_wt_data;
   logic              o_wt_ready;
   logic              i_act_valid;
   vec_t              i_act_data;
   logic              i_act_last;
   logic              o_act_ready;
   logic [ROWS*9-1:0] o_west_data;
   logic [31:0]       o_north_data;
   logic              o_busy;
   logic              o_done;

   systolic_feeder #(.ROWS(ROWS)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_wt_valid  (i_wt_valid),
      .i_wt_data   (i_wt_data),
      .o_wt_ready  (o_wt_ready),
      .i_act_valid (i_act_valid),
      .i_act_data  (i_act_data),
      .i_act_last  (i_act_last),
      .o_act_ready (o_act_ready),
      .o_west_data (o_west_data),
      .o_north_data(o_north_data),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   ev_t   lane_q [ROWS][$];
   ev_t   north_q[$];
   wdir_t dir_w[$];
   vdir_t dir_v[$];

   bit   mon_en = 1'b0;
   logic e_wtr, e_actr, e_busy, e_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the oldest expectation.
   logic [8:0] lane_val;
   ev_t        mev;
   always @(negedge i_clk) begin
      if (mon_en) begin
         for (int r = 0; r < ROWS; r++) begin
            lane_val = o_west_data[(ROWS-r)*9-1 -: 9];
            if (lane_val[8]) begin
               if (lane_q[r].size() == 0) begin
                  check($sformatf("lane%0d_unexpected", r), 64'(lane_val), 64'h0);
               end else begin
                  mev = lane_q[r].pop_front();
                  check($sformatf("lane%0d_data", r), 64'(lane_val), 64'({1'b1, mev.d}));
                  check($sformatf("lane%0d_time", r), 64'(cyc), 64'(mev.cyc));
               end
            end else begin
               check($sformatf("lane%0d_bubble", r), 64'(lane_val), 64'h0);
               if (lane_q[r].size() > 0 && lane_q[r][0].cyc <= cyc) begin
                  mev = lane_q[r].pop_front();
                  check($sformatf("lane%0d_missing", r), 64'(lane_val), 64'({1'b1, mev.d}));
               end
            end
         end
         if (o_north_data != 32'h0) begin
            if (north_q.size() == 0) begin
               check("north_unexpected", 64'(o_north_data), 64'h0);
            end else begin
               mev = north_q.pop_front();
               check("north_data", 64'(o_north_data), 64'(mev.d));
               check("north_time", 64'(cyc), 64'(mev.cyc));
            end
         end else if (north_q.size() > 0 && north_q[0].cyc <= cyc) begin
            mev = north_q.pop_front();
            check("north_missing", 64'(o_north_data), 64'(mev.d));
         end
         check("wt_ready",  64'(o_wt_ready),  64'(e_wtr));
         check("act_ready", 64'(o_act_ready), 64'(e_actr));
         check("busy",      64'(o_busy),      64'(e_busy));
         check("done",      64'(o_done),      64'(e_done));
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_idle();
      i_start     = 1'b0;
      i_wt_valid  = 1'b0;
      i_wt_data   = 8'($urandom);
      i_act_valid = 1'b0;
      i_act_data  = vec_t'($urandom);
      i_act_last  = 1'($urandom);
   endtask

   task automatic set_exp(input logic wtr, input logic actr, input logic busy, input logic done);
      e_wtr  = wtr;
      e_actr = actr;
      e_busy = busy;
      e_done = done;
   endtask

   // One job from the IDLE cycle through the idle cycle after DONE. Directed queues
   // override random weights/vectors; abort returns mid-stream with lanes in flight.
   task automatic run_job(input int nvec_rand, input bit abort);
      int nvec;
      drive_idle();
      i_start = 1'b1;
      set_exp(0, 0, 0, 0);
      tick();

      for (int i = 0; i < ROWS; i++) begin
         int         gap;
         logic [7:0] wd;
         wdir_t      w;
         if (dir_w.size() > 0) begin
            w   = dir_w.pop_front();
            gap = w.gap;
            wd  = w.d;
         end else begin
            gap = $urandom_range(0, 2);
            wd  = 8'($urandom_range(1, 255));
         end
         repeat (gap) begin
            drive_idle();
            i_act_valid = 1'b1;
            i_start     = 1'($urandom);
            set_exp(1, 0, 1, 0);
            tick();
         end
         drive_idle();
         i_wt_valid  = 1'b1;
         i_wt_data   = wd;
         i_act_valid = (i == ROWS - 1);
         north_q.push_back('{cyc: cyc + 1, d: wd});
         set_exp(1, 0, 1, 0);
         tick();
      end

      nvec = (dir_v.size() > 0) ? dir_v.size() : nvec_rand;
      for (int v = 0; v < nvec; v++) begin
         int    gap;
         vec_t  vd;
         vdir_t dv;
         if (dir_v.size() > 0) begin
            dv  = dir_v.pop_front();
            gap = dv.gap;
            vd  = dv.d;
         end else begin
            gap = abort ? 0 : $urandom_range(0, 2);
            vd  = vec_t'($urandom);
         end
         repeat (gap) begin
            drive_idle();
            i_wt_valid = 1'($urandom);
            i_start    = 1'($urandom);
            set_exp(0, 1, 1, 0);
            tick();
         end
         drive_idle();
         i_act_valid = 1'b1;
         i_act_data  = vd;
         i_act_last  = !abort && (v == nvec - 1);
         i_start     = 1'($urandom);
         for (int r = 0; r < ROWS; r++)
            lane_q[r].push_back('{cyc: cyc + 1 + r, d: vd[(ROWS-r)*8-1 -: 8]});
         set_exp(0, 1, 1, 0);
         tick();
      end
      if (abort) return;

      repeat (ROWS) begin
         drive_idle();
         i_act_valid = 1'b1;
         i_wt_valid  = 1'($urandom);
         i_start     = 1'($urandom);
         set_exp(0, 0, 1, 0);
         tick();
      end
      drive_idle();
      i_start = 1'b1;
      set_exp(0, 0, 1, 1);
      tick();
      drive_idle();
      set_exp(0, 0, 0, 0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_west"},      64'(o_west_data),  64'h0);
      check({tag, "_north"},     64'(o_north_data), 64'h0);
      check({tag, "_wt_ready"},  64'(o_wt_ready),   64'h0);
      check({tag, "_act_ready"}, 64'(o_act_ready),  64'h0);
      check({tag, "_busy"},      64'(o_busy),       64'h0);
      check({tag, "_done"},      64'(o_done),       64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst_n = 1'b0;
      drive_idle();
      set_exp(0, 0, 0, 0);
      #1;
      check_all_zero("reset");
      @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      tick();
      mon_en = 1'b1;
      repeat (2) tick();

      // Back-to-back weights 11/22/33 then one last vector {01,02,03}.
      dir_w.push_back('{gap: 0, d: 8'h11});
      dir_w.push_back('{gap: 0, d: 8'h22});
      dir_w.push_back('{gap: 0, d: 8'h33});
      dir_v.push_back('{gap: 0, d: vec_t'(24'h010203)});
      run_job(0, 1'b0);

      // Weight valid toggling 1,0,1,0,1; vectors A, bubble, B(last).
      dir_w.push_back('{gap: 0, d: 8'h5a});
      dir_w.push_back('{gap: 1, d: 8'ha5});
      dir_w.push_back('{gap: 1, d: 8'h3c});
      dir_v.push_back('{gap: 0, d: vec_t'(24'haabbcc)});
      dir_v.push_back('{gap: 1, d: vec_t'(24'h112233)});
      run_job(0, 1'b0);

      for (int j = 0; j < 6; j++) run_job($urandom_range(1, 6), 1'b0);

      // Asynchronous reset between edges while lanes hold data.
      run_job(4, 1'b1);
      mon_en = 1'b0;
      #2 i_rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      for (int r = 0; r < ROWS; r++) lane_q[r].delete();
      north_q.delete();
      drive_idle();
      repeat (2) @(posedge i_clk);
      #3 i_rst_n = 1'b1;
      tick();
      set_exp(0, 0, 0, 0);
      mon_en = 1'b1;
      repeat (6) begin
         drive_idle();
         i_wt_valid  = 1'b1;
         i_act_valid = 1'b1;
         tick();
      end

      for (int j = 0; j < 2; j++) run_job($urandom_range(1, 5), 1'b0);

      repeat (ROWS + 1) tick();
      mon_en = 1'b0;
      for (int r = 0; r < ROWS; r++)
         check($sformatf("lane%0d_left", r), 64'(lane_q[r].size()), 64'h0);
      check("north_left", 64'(north_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 9, meaning number of PE rows fed (ROWS >= 2, ROWS <= 16).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_start  input  1  one-cycle request to begin a weight-load/stream job.
REQ-005 SHALL have port i_wt_valid  input  1  weight byte valid.
REQ-006 SHALL have port i_wt_data  input  8  weight byte.
REQ-007 SHALL have port o_wt_ready  output  1  feeder accepts weight this cycle.
REQ-008 SHALL have port i_act_valid  input  1  activation vector valid.
REQ-009 SHALL have port i_act_data  input  ROWS*8  activation vector; row r at bits [(ROWS-r)*8-1 -: 8].
REQ-010 SHALL have port i_act_last  input  1  qualifies final vector of job (sampled with i_act_valid).
REQ-011 SHALL have port o_act_ready  output  1  feeder accepts vector this cycle.
REQ-012 SHALL have port o_west_data  output  ROWS*9  skewed lanes to array west inputs; lane r at bits [(ROWS-r)*9-1 -: 9], bit 8 = lane valid, bits 7:0 = data.
REQ-013 SHALL have port o_north_data  output  32  to array north input; weight byte in bits 7:0 during load, zero otherwise.
REQ-014 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse at job end.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN, DONE.
REQ-017 IDLE -> LOAD_W on i_start; i_start in any other state SHALL be ignored.
REQ-018 LOAD_W: o_wt_ready=1; each handshake (valid&ready) SHALL register o_north_data={24'b0,i_wt_data} for exactly one cycle, otherwise o_north_data=0.
REQ-019 Weights SHALL be presented bottom-row first (row ROWS-1 first, row 0 last); a 4-bit counter counts handshakes; after the ROWS-th handshake FSM -> STREAM next cycle.
REQ-020 LOAD_W gaps (i_wt_valid=0) SHALL hold the counter and drive o_north_data=0.
REQ-021 STREAM: o_act_ready=1, o_wt_ready=0, o_north_data=0 (partial-sum seed).
REQ-022 Accepted vector at edge t: lane r SHALL present {1'b1, row r byte} on o_west_data during cycle t+1+r (per-lane shift register of depth r+1).
REQ-023 Cycle without handshake SHALL inject {1'b0,8'h00} bubble into every lane entry point; bubbles keep the same skew.
REQ-024 Handshake with i_act_last=1 SHALL move FSM to DRAIN; o_act_ready=0 outside STREAM.
REQ-025 DRAIN SHALL last ROWS cycles injecting bubbles, so lane ROWS-1 has emitted the last vector before DONE.
REQ-026 DONE SHALL last one cycle with o_done=1, then -> IDLE; o_busy=0 in DONE? No: o_busy=1 in DONE, 0 only in IDLE.
REQ-027 o_west_data and o_north_data SHALL be registered outputs (no combinational path from inputs).
REQ-028 A vector with i_act_valid=1 arriving in same cycle as LOAD_W->STREAM transition SHALL not be accepted (ready still 0 that cycle).

Reset
REQ-029 i_rst_n=0 SHALL immediately force FSM=IDLE, weight counter=0, all lane shift registers=0, o_west_data=0, o_north_data=0, o_wt_ready=0, o_act_ready=0, o_busy=0, o_done=0.
REQ-030 Reset asserted mid-job SHALL discard all in-flight lanes; after release the feeder SHALL wait for a new i_start.

Verification
REQ-031 ROWS=3, i_start then weights 0x11,0x22,0x33 back-to-back -> o_north_data low byte 0x11,0x22,0x33 on three consecutive cycles, then 0; FSM in STREAM next cycle.
REQ-032 ROWS=3, single vector {r0=0x01,r1=0x02,r2=0x03} with last at edge t -> lane0=0x101 at t+1, lane1=0x102 at t+2, lane2=0x103 at t+3; o_done pulse at t+ROWS+1=t+4 (DONE cycle after 3 DRAIN cycles); other lane slots 0x000.
REQ-033 ROWS=3, vectors A, bubble, B(last) -> each lane shows A, 0x000, B with per-lane offsets 1,2,3; no vector lost.
REQ-034 Weight stream with i_wt_valid toggling 1,0,1,0,1 -> exactly 3 weights emitted, o_north_data=0 in gap cycles, transition only after third.
REQ-035 i_start pulsed during STREAM and DRAIN -> no effect; i_act_valid held during LOAD_W -> o_act_ready=0, nothing emitted.
REQ-036 i_rst_n dropped asynchronously (between edges) during STREAM with lanes full -> all outputs 0 before next edge; post-release no o_done until a new job completes.
